mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DBITS, 32, data/address width; only 32 is supported.
REQ-002 Parameter REGNOBITS, 5, register-number width.
REQ-003 Port clk  input  1  sole clock, all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Ports from AGEX, all inputs: agex_valid 1 (slot holds an instruction), agex_op IOPBITS (decoded op), agex_addr DBITS (ALU result / effective address), agex_wdata DBITS (store data, regval2), agex_rd REGNOBITS, agex_wr_reg 1, agex_pc DBITS, agex_inst INSTBITS.
REQ-006 Port mem_stall  output  1  freeze AGEX/DE/FE latches this cycle.
REQ-007 Data-memory ports: dmem_req out 1, dmem_we out 1, dmem_addr out DBITS (word-aligned), dmem_be out 4, dmem_wdata out DBITS, dmem_ready in 1 (request accepted), dmem_rvalid in 1, dmem_rdata in DBITS.
REQ-008 MEM latch outputs (registered): mem_valid 1, mem_result DBITS, mem_rd REGNOBITS, mem_wr_reg 1, mem_pc DBITS, mem_inst INSTBITS, mem_misalign 1.
REQ-009 Forwarding outputs to DE/AGEX (combinational from the MEM latch): fwd_rd REGNOBITS, fwd_wr_reg 1 (=mem_valid&mem_wr_reg), fwd_value DBITS (=mem_result).

Function
REQ-010 Memory ops: LB, LH, LW, LBU, LHU, SB, SH, SW; all other ops are non-memory.
REQ-011 Non-memory op with agex_valid: the latch captures it next edge, mem_result=agex_addr; latency 1; no dmem activity.
REQ-012 FSM states IDLE, REQ, WAIT; reset state IDLE.
REQ-013 IDLE + valid aligned memory op: dmem_req=1 combinationally the same cycle; dmem_ready=1 -> store completes (latch captures, wr_reg forced 0), load -> WAIT; dmem_ready=0 -> REQ.
REQ-014 REQ: dmem_req and all dmem_* held stable until dmem_ready; on accept, store -> IDLE with latch capture, load -> WAIT.
REQ-015 WAIT: dmem_req=0; on dmem_rvalid, load data formatted, latch captures, -> IDLE; dmem_rvalid in the accept cycle is legal only from the next cycle.
REQ-016 mem_stall=1 whenever a valid memory op is present and does not complete this cycle; mem_valid=0 on every stalled cycle (bubble).
REQ-017 Alignment: dmem_addr=agex_addr with bits[1:0]=0; byte ops be=1<<addr[1:0]; half ops be=3<<addr[1:0]; word be=4'hF; dmem_wdata=agex_wdata replicated into the selected lanes.
REQ-018 Load formatting: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend to DBITS.
REQ-019 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no dmem_req, 1-cycle pass-through, mem_misalign=1, mem_result=0, mem_wr_reg=0.
REQ-020 agex_valid=0 in IDLE: mem_valid=0 next cycle, other latch fields don't-care but deterministic (held).
REQ-021 Inputs are stable while mem_stall=1 (upstream guarantee); the block does not re-latch them.
REQ-022 dmem_rvalid in IDLE or REQ is ignored.

Reset
REQ-023 reset low: FSM->IDLE, mem_valid=0, mem_wr_reg=0, mem_misalign=0, mem_result/mem_pc/mem_inst=0, mem_rd=0, asynchronously.
REQ-024 dmem_req and mem_stall deassert immediately on reset assertion, including mid-REQ or WAIT; a late dmem_rvalid after reset release is dropped.

Structure
REQ-025 Op encodings, IOPBITS, INSTBITS, DBITS, REGNOBITS, and MEM latch width/packing order come from VX_define.vh; FSM state encoding is local.
REQ-026 One combinational sub-module mem_align (byte-enable, write-lane replication, load extract/extend) is instantiated once.

Verification
REQ-027 ADD result 0x1234 rd=5 -> next cycle mem_valid=1, mem_result=0x1234, fwd_rd=5, no dmem_req.
REQ-028 SW addr 0x100 data 0xDEADBEEF, dmem_ready=1 immediately -> be=4'hF, 1-cycle, mem_wr_reg=0, mem_stall=0.
REQ-029 LB addr 0x103, ready after 2 cycles, rvalid 3 cycles later with rdata 0x80000000 -> mem_stall high 5 cycles, mem_result=0xFFFFFF80.
REQ-030 LHU addr 0x102, rdata 0xABCD0000 -> mem_result=0x0000ABCD; SH addr 0x102 data 0x1234 -> be=4'b1100, wdata=0x12341234.
REQ-031 LW addr 0x101 -> mem_misalign=1, no dmem_req, mem_wr_reg=0.
REQ-032 reset low during WAIT, then rvalid after release -> IDLE, mem_valid stays 0, stall 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Purpose: shared widths, op encodings, FSM states and MEM latch layout for the MEM stage.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int DBITS     = 32;
    localparam int REGNOBITS = 5;
    localparam int IOPBITS   = 6;
    localparam int INSTBITS  = 32;

    // Decoded op encodings shared with DE/AGEX.
    localparam logic [IOPBITS-1:0] OP_ADD = 6'h00;
    localparam logic [IOPBITS-1:0] OP_SUB = 6'h01;
    localparam logic [IOPBITS-1:0] OP_AND = 6'h02;
    localparam logic [IOPBITS-1:0] OP_OR  = 6'h03;
    localparam logic [IOPBITS-1:0] OP_LB  = 6'h10;
    localparam logic [IOPBITS-1:0] OP_LH  = 6'h11;
    localparam logic [IOPBITS-1:0] OP_LW  = 6'h12;
    localparam logic [IOPBITS-1:0] OP_LBU = 6'h13;
    localparam logic [IOPBITS-1:0] OP_LHU = 6'h14;
    localparam logic [IOPBITS-1:0] OP_SB  = 6'h18;
    localparam logic [IOPBITS-1:0] OP_SH  = 6'h19;
    localparam logic [IOPBITS-1:0] OP_SW  = 6'h1A;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } mem_state_e;

    // MEM latch, packed MSB-first in this field order.
    typedef struct packed {
        logic                 valid;
        logic [DBITS-1:0]     result;
        logic [REGNOBITS-1:0] rd;
        logic                 wr_reg;
        logic [DBITS-1:0]     pc;
        logic [INSTBITS-1:0]  inst;
        logic                 misalign;
    } mem_latch_t;

    function automatic logic is_load(input logic [IOPBITS-1:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [IOPBITS-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_mem_op(input logic [IOPBITS-1:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic mem_size_e op_size(input logic [IOPBITS-1:0] op);
        mem_size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_B;
            OP_LH, OP_LHU, OP_SH: sz = SZ_H;
            default:              sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic op_signed(input logic [IOPBITS-1:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Purpose: byte-enable generation, store-lane replication and load extract/extend.
// Latency: purely combinational.
// Backpressure: none; ports: op_i/ofs_i/wdata_i/rdata_i in, be_o/wdata_o/rdata_o out.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [IOPBITS-1:0] op_i,
    input  logic [1:0]         ofs_i,
    input  logic [31:0]        wdata_i,
    input  logic [31:0]        rdata_i,
    output logic [3:0]         be_o,
    output logic [31:0]        wdata_o,
    output logic [31:0]        rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o    = 4'hF;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        // Bring the addressed lane down to bit 0 before extending.
        shifted = rdata_i >> {ofs_i, 3'b000};
        case (op_size(op_i))
            SZ_B: begin
                be_o    = 4'b0001 << ofs_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = op_signed(op_i) ? {{24{shifted[7]}}, shifted[7:0]}
                                          : {24'h0, shifted[7:0]};
            end
            SZ_H: begin
                be_o    = 4'b0011 << ofs_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = op_signed(op_i) ? {{16{shifted[15]}}, shifted[15:0]}
                                          : {16'h0, shifted[15:0]};
            end
            default: begin
                be_o    = 4'hF;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Purpose: pipeline MEM stage; issues loads/stores to dmem, formats load data, drives MEM latch + forwarding.
// Latency: 1 cycle for non-memory/misaligned/immediately-accepted stores; loads wait for dmem_rvalid.
// Backpressure: mem_stall freezes upstream while a memory op is pending; dmem_* held stable until dmem_ready.
// Ports: clk/reset (async active-low); agex_* instruction in; dmem_* memory request/response;
//        mem_* registered MEM latch; fwd_* combinational forwarding view of the latch.
module mem_stage #(
    parameter int DBITS     = mem_stage_pkg::DBITS,     // only 32 supported
    parameter int REGNOBITS = mem_stage_pkg::REGNOBITS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             agex_valid,
    input  logic [mem_stage_pkg::IOPBITS-1:0] agex_op,
    input  logic [DBITS-1:0]                 agex_addr,
    input  logic [DBITS-1:0]                 agex_wdata,
    input  logic [REGNOBITS-1:0]             agex_rd,
    input  logic                             agex_wr_reg,
    input  logic [DBITS-1:0]                 agex_pc,
    input  logic [mem_stage_pkg::INSTBITS-1:0] agex_inst,
    output logic                             mem_stall,
    output logic                             dmem_req,
    output logic                             dmem_we,
    output logic [DBITS-1:0]                 dmem_addr,
    output logic [3:0]                       dmem_be,
    output logic [DBITS-1:0]                 dmem_wdata,
    input  logic                             dmem_ready,
    input  logic                             dmem_rvalid,
    input  logic [DBITS-1:0]                 dmem_rdata,
    output logic                             mem_valid,
    output logic [DBITS-1:0]                 mem_result,
    output logic [REGNOBITS-1:0]             mem_rd,
    output logic                             mem_wr_reg,
    output logic [DBITS-1:0]                 mem_pc,
    output logic [mem_stage_pkg::INSTBITS-1:0] mem_inst,
    output logic                             mem_misalign,
    output logic [REGNOBITS-1:0]             fwd_rd,
    output logic                             fwd_wr_reg,
    output logic [DBITS-1:0]                 fwd_value
);

    import mem_stage_pkg::*;

    mem_state_e state_q, state_d;
    mem_latch_t latch_q, latch_d;
    mem_latch_t cap;

    logic             is_mem, is_st, misalign, go;
    logic             req, stall;
    logic [3:0]       be;
    logic [DBITS-1:0] st_data, ld_data;

    mem_align u_align (
        .op_i    (agex_op),
        .ofs_i   (agex_addr[1:0]),
        .wdata_i (agex_wdata),
        .rdata_i (dmem_rdata),
        .be_o    (be),
        .wdata_o (st_data),
        .rdata_o (ld_data)
    );

    always_comb begin
        is_mem = agex_valid && is_mem_op(agex_op);
        is_st  = is_store(agex_op);
        case (op_size(agex_op))
            SZ_H:    misalign = is_mem && agex_addr[0];
            SZ_W:    misalign = is_mem && (agex_addr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
        go = is_mem && !misalign;
    end

    // Default capture image; stores keep the effective address as result
    // but never write the register file.
    always_comb begin
        cap.valid    = 1'b1;
        cap.result   = agex_addr;
        cap.rd       = agex_rd;
        cap.wr_reg   = agex_wr_reg;
        cap.pc       = agex_pc;
        cap.inst     = agex_inst;
        cap.misalign = 1'b0;
    end

    always_comb begin
        state_d       = state_q;
        latch_d       = latch_q;
        latch_d.valid = 1'b0;      // bubble unless something completes
        req           = 1'b0;
        stall         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (agex_valid) begin
                    if (go) begin
                        req = 1'b1;
                        if (dmem_ready && is_st) begin
                            latch_d        = cap;
                            latch_d.wr_reg = 1'b0;
                        end else begin
                            stall   = 1'b1;
                            state_d = dmem_ready ? ST_WAIT : ST_REQ;
                        end
                    end else if (misalign) begin
                        latch_d          = cap;
                        latch_d.result   = '0;
                        latch_d.wr_reg   = 1'b0;
                        latch_d.misalign = 1'b1;
                    end else begin
                        latch_d = cap;
                    end
                end
            end
            ST_REQ: begin
                req = 1'b1;
                if (dmem_ready && is_st) begin
                    latch_d        = cap;
                    latch_d.wr_reg = 1'b0;
                    state_d        = ST_IDLE;
                end else begin
                    stall = 1'b1;
                    if (dmem_ready) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    latch_d        = cap;
                    latch_d.result = ld_data;
                    state_d        = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            latch_q <= '0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
        end
    end

    // Gated by reset so request and stall drop the instant reset asserts,
    // even though the IDLE path is combinational from agex_*.
    assign dmem_req   = reset && req;
    assign mem_stall  = reset && stall;
    assign dmem_we    = dmem_req && is_st;
    assign dmem_addr  = {agex_addr[DBITS-1:2], 2'b00};
    assign dmem_be    = be;
    assign dmem_wdata = st_data;

    assign mem_valid    = latch_q.valid;
    assign mem_result   = latch_q.result;
    assign mem_rd       = latch_q.rd;
    assign mem_wr_reg   = latch_q.wr_reg;
    assign mem_pc       = latch_q.pc;
    assign mem_inst     = latch_q.inst;
    assign mem_misalign = latch_q.misalign;

    assign fwd_rd     = latch_q.rd;
    assign fwd_wr_reg = latch_q.valid && latch_q.wr_reg;
    assign fwd_value  = latch_q.result;

endmodule

// File: tb/tb_mem_stage.sv
// Purpose: self-checking bench for mem_stage with a scoreboard of expected MEM latch contents.
// Latency: drives at negedge, samples #1 later; latch monitored at every negedge.
// Backpressure: dmem_ready/dmem_rvalid delays programmable per transaction.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        agex_valid;
    logic [5:0]  agex_op;
    logic [31:0] agex_addr, agex_wdata, agex_pc, agex_inst;
    logic [4:0]  agex_rd;
    logic        agex_wr_reg;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_valid, mem_wr_reg, mem_misalign, fwd_wr_reg;
    logic [31:0] mem_result, mem_pc, mem_inst, fwd_value;
    logic [4:0]  mem_rd, fwd_rd;

    int vectors = 0;
    int miscompares = 0;
    int pc_ctr = 32'h1000;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wr;
        logic        mis;
        logic [31:0] pc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .agex_valid(agex_valid), .agex_op(agex_op), .agex_addr(agex_addr),
        .agex_wdata(agex_wdata), .agex_rd(agex_rd), .agex_wr_reg(agex_wr_reg),
        .agex_pc(agex_pc), .agex_inst(agex_inst),
        .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd),
        .mem_wr_reg(mem_wr_reg), .mem_pc(mem_pc), .mem_inst(mem_inst),
        .mem_misalign(mem_misalign),
        .fwd_rd(fwd_rd), .fwd_wr_reg(fwd_wr_reg), .fwd_value(fwd_value)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every valid latch must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && mem_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_mem_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("mem_result", mem_result, e.result);
                chk("mem_rd", {27'd0, mem_rd}, {27'd0, e.rd});
                chk("mem_wr_reg", {31'd0, mem_wr_reg}, {31'd0, e.wr});
                chk("mem_misalign", {31'd0, mem_misalign}, {31'd0, e.mis});
                chk("mem_pc", mem_pc, e.pc);
                chk("mem_inst", mem_inst, ~e.pc);
            end
        end
    end

    task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic wr);
        agex_valid  = 1'b1;
        agex_op     = op;
        agex_addr   = addr;
        agex_wdata  = wd;
        agex_rd     = rd;
        agex_wr_reg = wr;
        agex_pc     = pc_ctr;
        agex_inst   = ~pc_ctr;
    endtask

    task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic wr, input logic mis);
        exp_t x;
        x.result = res; x.rd = rd; x.wr = wr; x.mis = mis; x.pc = pc_ctr;
        sb.push_back(x);
        pc_ctr += 4;
    endtask

    // One memory-op transaction with programmable ready / rvalid delays.
    task automatic mem_txn(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdata,
                           input int rdy_dly, input int rv_dly, input logic exp_req,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_res, input logic exp_wr, input logic exp_mis,
                           input int exp_stalls);
        int acc = -1;
        int stalls = 0;
        int reqs = 0;
        bit done = 0;
        logic st = is_store(op);
        drive(op, addr, wd, 5'd9, 1'b1);
        dmem_rdata = rdata;
        push(exp_res, 5'd9, exp_wr, exp_mis);
        for (int c = 0; c < 40 && !done; c++) begin
            dmem_ready  = (acc < 0) && (c >= rdy_dly);
            dmem_rvalid = (acc >= 0) && (c == acc + rv_dly);
            #1;
            if (dmem_req) begin
                reqs++;
                chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
                chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
                chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, st});
                if (st) chk({tag, "_wdata"}, dmem_wdata, exp_wd);
                if (dmem_ready) acc = c;
            end
            if (mem_stall) stalls++;
            else done = 1;
            @(negedge clk);
        end
        if (!done) chk({tag, "_timeout"}, 32'd1, 32'd0);
        agex_valid  = 1'b0;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        chk({tag, "_req_seen"}, {31'd0, reqs > 0}, {31'd0, exp_req});
        chk({tag, "_stalls"}, stalls, exp_stalls);
    endtask

    initial begin
        reset = 1'b0;
        agex_valid = 0; agex_op = OP_ADD; agex_addr = 0; agex_wdata = 0;
        agex_rd = 0; agex_wr_reg = 0; agex_pc = 0; agex_inst = 0;
        dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_result", mem_result, 32'd0);
        chk("rst_mem_rd", {27'd0, mem_rd}, 32'd0);
        chk("rst_mem_wr_reg", {31'd0, mem_wr_reg}, 32'd0);
        chk("rst_mem_misalign", {31'd0, mem_misalign}, 32'd0);
        chk("rst_mem_pc", mem_pc, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // ALU op passes straight through in one cycle.
        drive(OP_ADD, 32'h1234, 32'h0, 5'd5, 1'b1);
        push(32'h1234, 5'd5, 1'b1, 1'b0);
        #1;
        chk("add_req", {31'd0, dmem_req}, 32'd0);
        chk("add_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        agex_valid = 1'b0;
        chk("fwd_rd", {27'd0, fwd_rd}, 32'd5);
        chk("fwd_wr_reg", {31'd0, fwd_wr_reg}, 32'd1);
        chk("fwd_value", fwd_value, 32'h1234);
        @(negedge clk);
        chk("bubble_fwd_wr", {31'd0, fwd_wr_reg}, 32'd0);

        //       tag    op      addr        wdata         rdata        rdy rv req be       wdata         result       wr mis stalls
        mem_txn("sw",  OP_SW,  32'h100, 32'hDEADBEEF, 32'h0,        0, 1, 1, 4'hF,    32'hDEADBEEF, 32'h100,      0, 0, 0);
        mem_txn("lb",  OP_LB,  32'h103, 32'h0,        32'h80000000, 2, 3, 1, 4'b1000, 32'h0,        32'hFFFFFF80, 1, 0, 5);
        mem_txn("lhu", OP_LHU, 32'h102, 32'h0,        32'hABCD0000, 0, 1, 1, 4'b1100, 32'h0,        32'h0000ABCD, 1, 0, 1);
        mem_txn("sh",  OP_SH,  32'h102, 32'h1234,     32'h0,        1, 1, 1, 4'b1100, 32'h12341234, 32'h102,      0, 0, 1);
        mem_txn("lwm", OP_LW,  32'h101, 32'h0,        32'h0,        0, 1, 0, 4'hF,    32'h0,        32'h0,        0, 1, 0);
        mem_txn("sb",  OP_SB,  32'h101, 32'h000000A5, 32'h0,        0, 1, 1, 4'b0010, 32'hA5A5A5A5, 32'h101,      0, 0, 0);
        mem_txn("lh",  OP_LH,  32'h100, 32'h0,        32'h00008001, 0, 2, 1, 4'b0011, 32'h0,        32'hFFFF8001, 1, 0, 2);
        mem_txn("lw",  OP_LW,  32'h104, 32'h0,        32'h12345678, 1, 2, 1, 4'hF,    32'h0,        32'h12345678, 1, 0, 3);
        mem_txn("lbu", OP_LBU, 32'h102, 32'h0,        32'h00FE0000, 0, 1, 1, 4'b0100, 32'h0,        32'h000000FE, 1, 0, 1);
        mem_txn("shm", OP_SH,  32'h103, 32'h5555,     32'h0,        0, 1, 0, 4'hF,    32'h0,        32'h0,        0, 1, 0);

        // Reset asserted while a load waits for data; late rvalid must be dropped.
        drive(OP_LW, 32'h200, 32'h0, 5'd7, 1'b1);
        dmem_ready = 1'b1;
        #1;
        chk("rw_req", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        chk("rw_wait_stall", {31'd0, mem_stall}, 32'd1);
        chk("rw_wait_req", {31'd0, dmem_req}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("rw_rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rw_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rw_rst_valid", {31'd0, mem_valid}, 32'd0);
        @(negedge clk);
        agex_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFEF00D;
        #1;
        chk("late_rv_stall", {31'd0, mem_stall}, 32'd0);
        chk("late_rv_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("late_rv_valid", {31'd0, mem_valid}, 32'd0);

        // FSM back in IDLE: a fresh ALU op must flow normally.
        drive(OP_OR, 32'h00C0FFEE, 32'h0, 5'd3, 1'b1);
        push(32'h00C0FFEE, 5'd3, 1'b1, 1'b0);
        @(negedge clk);
        agex_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
